// File: rtl/sample_frame_buffer.sv
// rtl/sample_frame_buffer.sv - ping-pong 64-sample frame buffer with block-average decimator feeding the FFT
module sample_frame_buffer #(
    parameter int FRAME_LEN      = 64,
    parameter int MAX_DECIM_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  decim_log2,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        fft_start,
    input  logic        fft_done,
    input  logic [5:0]  sample_addr,
    output logic [15:0] sample_in,
    output logic [6:0]  wr_level,
    output logic [15:0] frame_count,
    output logic        overrun,
    input  logic        overrun_clr
);
    localparam int AW   = $clog2(FRAME_LEN);
    localparam int ACCW = 16 + MAX_DECIM_LOG2;
    localparam logic [MAX_DECIM_LOG2:0] ONE = 1;

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t state, state_next;

    logic [15:0] mem [0:2*FRAME_LEN-1];

    logic                       wr_bank;
    logic                       rd_owned;
    logic [1:0]                 d_lat;
    logic signed [ACCW-1:0]     acc;
    logic [MAX_DECIM_LOG2-1:0]  dec_cnt;

    logic [1:0]                 d_eff;
    logic [MAX_DECIM_LOG2:0]    dec_max;
    logic signed [ACCW-1:0]     sum;
    logic [15:0]                wr_word;
    logic                       accept;
    logic                       group_done;
    logic                       frame_done;
    logic                       drop;
    logic                       swap;

    // The averaging factor may only change at a frame boundary with an empty accumulator.
    always_comb begin
        d_eff      = (wr_level == '0 && dec_cnt == '0) ? decim_log2 : d_lat;
        dec_max    = (ONE << d_eff) - ONE;
        sum        = acc + $signed({{MAX_DECIM_LOG2{in_data[15]}}, in_data});
        wr_word    = 16'(sum >>> d_eff);
        accept     = enable && in_valid && (state == S_FILL);
        group_done = accept && ({1'b0, dec_cnt} == dec_max);
        frame_done = group_done && (wr_level == 7'(FRAME_LEN - 1));
        drop       = enable && in_valid && (state == S_FULL);
        swap       = 1'b0;
        state_next = state;
        if (!enable) begin
            state_next = S_FILL;
        end else begin
            case (state)
                S_FILL: begin
                    if (frame_done) begin
                        if (!rd_owned || fft_done) swap = 1'b1;
                        else                       state_next = S_FULL;
                    end
                end
                S_FULL: begin
                    if (fft_done) begin
                        swap       = 1'b1;
                        state_next = S_FILL;
                    end
                end
                default: state_next = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FILL;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank     <= 1'b0;
            rd_owned    <= 1'b0;
            d_lat       <= '0;
            acc         <= '0;
            dec_cnt     <= '0;
            wr_level    <= '0;
            fft_start   <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            fft_start <= swap;
            d_lat     <= d_eff;

            if (swap) begin
                wr_bank     <= ~wr_bank;
                rd_owned    <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (fft_done) begin
                rd_owned <= 1'b0;
            end

            // Completing a frame without a swap leaves wr_level at 64, which marks FULL.
            if (!enable || swap)  wr_level <= '0;
            else if (group_done)  wr_level <= wr_level + 7'd1;

            if (!enable || state == S_FULL || group_done) begin
                acc     <= '0;
                dec_cnt <= '0;
            end else if (accept) begin
                acc     <= sum;
                dec_cnt <= dec_cnt + 1'b1;
            end

            if (drop)             overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && group_done) mem[{wr_bank, wr_level[AW-1:0]}] <= wr_word;
    end

    assign sample_in = mem[{~wr_bank, sample_addr}];

endmodule

// File: tb/tb_sample_frame_buffer.sv
// tb/tb_sample_frame_buffer.sv - self-checking bench for sample_frame_buffer
module tb_sample_frame_buffer;
    logic        clk = 1'b0;
    logic        rst, enable, in_valid, fft_done, overrun_clr;
    logic [1:0]  decim_log2;
    logic [15:0] in_data;
    logic        fft_start;
    logic [5:0]  sample_addr;
    logic [15:0] sample_in;
    logic [6:0]  wr_level;
    logic [15:0] frame_count;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sample_frame_buffer dut (
        .clk(clk), .rst(rst), .enable(enable), .decim_log2(decim_log2),
        .in_valid(in_valid), .in_data(in_data), .fft_start(fft_start),
        .fft_done(fft_done), .sample_addr(sample_addr), .sample_in(sample_in),
        .wr_level(wr_level), .frame_count(frame_count), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    typedef struct {
        int d;
        int g0[8];
        int g1[8];
        int e0;
        int e1;
    } vec_t;

    // Reference model: frames as queues of averaged words, groups as running sums.
    int  m_wq[$];
    int  m_rd[64];
    bit  m_rd_known, m_full, m_owned, m_start, m_ovr;
    int  m_sum, m_n, m_d, m_fc;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_div(int s, int m);
        int q = s / m;
        if ((s % m != 0) && (s < 0)) q--;
        return q;
    endfunction

    task automatic model_reset();
        m_wq.delete();
        m_rd_known = 0; m_full = 0; m_owned = 0; m_start = 0; m_ovr = 0;
        m_sum = 0; m_n = 0; m_d = 0; m_fc = 0;
    endtask

    task automatic model_swap();
        for (int i = 0; i < 64; i++) m_rd[i] = m_wq[i];
        m_wq.delete();
        m_full = 0; m_start = 1; m_owned = 1; m_rd_known = 1;
        m_fc = (m_fc + 1) % 65536;
    endtask

    task automatic model_step();
        bit drop = 0;
        m_start = 0;
        if (!enable) begin
            m_sum = 0; m_n = 0; m_wq.delete(); m_full = 0;
        end else if (m_full) begin
            if (in_valid) drop = 1;
            if (fft_done) model_swap();
        end else begin
            if (m_wq.size() == 0 && m_n == 0) m_d = int'(decim_log2);
            if (in_valid) begin
                m_sum += int'($signed(in_data));
                m_n++;
                if (m_n == (1 << m_d)) begin
                    m_wq.push_back(floor_div(m_sum, 1 << m_d));
                    m_sum = 0; m_n = 0;
                    if (m_wq.size() == 64) begin
                        if (!m_owned || fft_done) model_swap();
                        else m_full = 1;
                    end
                end
            end
        end
        if (fft_done && !m_start) m_owned = 0;
        if (drop) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("fft_start", int'(fft_start), int'(m_start));
        check("wr_level", int'(wr_level), m_full ? 64 : m_wq.size());
        check("frame_count", int'(frame_count), m_fc);
        check("overrun", int'(overrun), int'(m_ovr));
    endtask

    task automatic cyc(bit v, int data, bit done);
        in_valid = v;
        in_data  = data[15:0];
        fft_done = done;
        tick();
        in_valid = 1'b0;
        fft_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; fft_done = 1'b0;
        overrun_clr = 1'b0; sample_addr = '0; in_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic read_check(string name, int addr, int exp);
        sample_addr = addr[5:0];
        #1;
        check(name, int'($signed(sample_in)), exp);
    endtask

    initial begin
        vec_t tbl[6];
        int   pulses;

        tbl[0] = '{2, '{1, 2, 3, 6, 0, 0, 0, 0}, '{-1, -2, -2, -2, 0, 0, 0, 0}, 3, -2};
        tbl[1] = '{0, '{-32768, 0, 0, 0, 0, 0, 0, 0}, '{32767, 0, 0, 0, 0, 0, 0, 0}, -32768, 32767};
        tbl[2] = '{3, '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767},
                      '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}, 32767, -32768};
        tbl[3] = '{1, '{-1, 0, 0, 0, 0, 0, 0, 0}, '{3, 4, 0, 0, 0, 0, 0, 0}, -1, 3};
        tbl[4] = '{3, '{1, 0, 0, 0, 0, 0, 0, 0}, '{-1, 0, 0, 0, 0, 0, 0, 0}, 0, -1};
        tbl[5] = '{1, '{-3, -4, 0, 0, 0, 0, 0, 0}, '{5, 6, 0, 0, 0, 0, 0, 0}, -4, 5};

        decim_log2 = 2'd0;
        do_reset();
        check("reset_fft_start", int'(fft_start), 0);
        check("reset_wr_level", int'(wr_level), 0);
        check("reset_frame_count", int'(frame_count), 0);
        check("reset_overrun", int'(overrun), 0);

        // Ramp at d=0.
        cyc(0, 0, 0);
        pulses = 0;
        for (int k = 0; k < 63; k++) begin
            cyc(1, k, 0);
            pulses += int'(fft_start);
        end
        check("ramp_early_start", pulses, 0);
        cyc(1, 63, 0);
        check("ramp_start_after_63", int'(fft_start), 1);
        cyc(0, 0, 0);
        check("ramp_start_one_cycle", int'(fft_start), 0);
        for (int k = 0; k < 64; k++) read_check("ramp_read", k, k);
        check("ramp_frame_count", int'(frame_count), 1);
        check("ramp_wr_level", int'(wr_level), 0);

        // Second frame with no fft_done fills to FULL.
        for (int k = 0; k < 64; k++) cyc(1, 1000 + k, 0);
        check("full_wr_level", int'(wr_level), 64);
        check("full_no_overrun_yet", int'(overrun), 0);
        cyc(1, 5, 0);
        check("full_drop_overrun", int'(overrun), 1);
        cyc(0, 0, 1);
        check("full_release_start", int'(fft_start), 1);
        for (int k = 0; k < 64; k++) read_check("frame2_read", k, 1000 + k);
        check("frame2_count", int'(frame_count), 2);

        // fft_done coincident with the 64th write while the read bank is owned.
        overrun_clr = 1'b1;
        cyc(0, 0, 0);
        overrun_clr = 1'b0;
        check("overrun_cleared", int'(overrun), 0);
        for (int k = 0; k < 63; k++) cyc(1, 2000 + k, 0);
        cyc(1, 2063, 1);
        check("coinc_start", int'(fft_start), 1);
        check("coinc_overrun", int'(overrun), 0);
        check("coinc_count", int'(frame_count), 3);
        read_check("coinc_read0", 0, 2000);
        read_check("coinc_read63", 63, 2063);

        // Reset mid-fill discards everything, including a sticky overrun.
        for (int k = 0; k < 64; k++) cyc(1, 3000 + k, 0);
        cyc(1, 1, 0);
        cyc(0, 0, 1);
        for (int k = 0; k < 30; k++) cyc(1, 500 + k, 0);
        do_reset();
        check("rst2_fft_start", int'(fft_start), 0);
        check("rst2_wr_level", int'(wr_level), 0);
        check("rst2_frame_count", int'(frame_count), 0);
        check("rst2_overrun", int'(overrun), 0);
        pulses = 0;
        for (int k = 0; k < 64; k++) begin
            cyc(1, 100 + k, 0);
            pulses += int'(fft_start);
        end
        check("rst2_pulses", pulses, 1);
        read_check("rst2_read0", 0, 100);

        // Enable low discards partial frame and ignores input; clear loses to a drop.
        for (int k = 0; k < 20; k++) cyc(1, 700 + k, 0);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) cyc(1, 800 + k, 0);
        check("disabled_overrun", int'(overrun), 0);
        check("disabled_wr_level", int'(wr_level), 0);
        enable = 1'b1;
        cyc(0, 0, 0);
        for (int k = 0; k < 64; k++) cyc(1, 900 + k, 0);
        overrun_clr = 1'b1;
        cyc(1, 7, 0);
        check("clr_vs_drop", int'(overrun), 1);
        cyc(0, 0, 0);
        check("clr_alone", int'(overrun), 0);
        overrun_clr = 1'b0;
        cyc(0, 0, 1);
        read_check("post_enable_read0", 0, 900);

        // Decimation table: two leading groups, then zeros to complete the frame.
        foreach (tbl[t]) begin
            decim_log2 = tbl[t].d[1:0];
            do_reset();
            cyc(0, 0, 0);
            pulses = 0;
            for (int i = 0; i < (1 << tbl[t].d); i++) begin
                cyc(1, tbl[t].g0[i], 0);
                pulses += int'(fft_start);
            end
            for (int i = 0; i < (1 << tbl[t].d); i++) begin
                cyc(1, tbl[t].g1[i], 0);
                pulses += int'(fft_start);
            end
            for (int i = 0; i < 62 * (1 << tbl[t].d); i++) begin
                cyc(1, 0, 0);
                pulses += int'(fft_start);
            end
            check("decim_pulses", pulses, 1);
            read_check("decim_word0", 0, tbl[t].e0);
            read_check("decim_word1", 1, tbl[t].e1);
            read_check("decim_word2", 2, 0);
        end

        // Randomized traffic against the model.
        for (int dd = 0; dd < 2; dd++) begin
            decim_log2 = 2'(dd);
            do_reset();
            cyc(0, 0, 0);
            for (int n = 0; n < 2500; n++) begin
                enable      = ($urandom_range(0, 99) != 0);
                in_valid    = ($urandom_range(0, 3) != 0);
                in_data     = 16'($urandom);
                fft_done    = ($urandom_range(0, 40) == 0);
                overrun_clr = ($urandom_range(0, 30) == 0);
                sample_addr = 6'($urandom);
                tick();
                if (m_rd_known)
                    check("rand_sample_in", int'($signed(sample_in)), m_rd[int'(sample_addr)]);
            end
            enable = 1'b1; in_valid = 1'b0; fft_done = 1'b0; overrun_clr = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
